// File: rtl/ea_calc_unit_if.sv
// Operand-path bundle between the decode/regfile side and the EA calculator.
interface ea_calc_unit_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             start;
  logic [1:0]       As;
  logic             Ad;
  logic             BW;
  logic [WIDTH-1:0] Sout;
  logic [WIDTH-1:0] Dout;
  logic [WIDTH-1:0] MDB_out;
  logic             mdb_valid;
  logic             mdb_ack;
  logic [WIDTH-1:0] src_addr;
  logic             src_addr_valid;
  logic [WIDTH-1:0] dst_addr;
  logic             dst_addr_valid;
  logic [WIDTH-1:0] incr_val;
  logic             incr_we;
  logic             busy;
  logic             done;

  modport master (
    output flush, start, As, Ad, BW, Sout, Dout, MDB_out, mdb_valid,
    input  mdb_ack, src_addr, src_addr_valid, dst_addr, dst_addr_valid,
           incr_val, incr_we, busy, done
  );

  modport slave (
    input  flush, start, As, Ad, BW, Sout, Dout, MDB_out, mdb_valid,
    output mdb_ack, src_addr, src_addr_valid, dst_addr, dst_addr_valid,
           incr_val, incr_we, busy, done
  );
endinterface

// File: rtl/ea_calc_unit.sv
// MSP430 effective-address calculator: source then destination address
// generation, autoincrement write-back, and a tapped register-value history
// so the addressing lines up with the core's pipeline timing.
module ea_calc_unit #(
  parameter int WIDTH      = 16,
  parameter int HIST_DEPTH = 3,
  parameter int SRC_TAP    = 0,
  parameter int DST_TAP    = 0
) (
  input logic           clk,
  input logic           rst,
  ea_calc_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SRC, DST, DONE} state_t;

  // Operation descriptor captured at start.
  typedef struct packed {
    logic [1:0] as;
    logic       ad;
    logic       bw;
  } op_t;

  state_t state, state_nx;
  op_t    op;

  logic [HIST_DEPTH-1:0][WIDTH-1:0] s_hist, d_hist;
  logic [WIDTH-1:0] s_cur, d_cur, src_sum, incr_step;

  logic [WIDTH-1:0] src_addr_q, dst_addr_q, incr_val_q;
  logic             src_vld_q, dst_vld_q;

  // Control strobes from the FSM into the datapath registers.
  logic latch_op, clr_vld, src_ld, dst_ld, incr_ld;
  logic mdb_ack, incr_we, done;

  assign s_cur     = s_hist[SRC_TAP];
  assign d_cur     = d_hist[DST_TAP];
  // Indexed mode adds the extension word; indirect modes use the register as-is.
  assign src_sum   = s_cur + ((op.as == 2'b01) ? bus.MDB_out : '0);
  assign incr_step = op.bw ? WIDTH'(1) : WIDTH'(2);

  // Register-value history; shifts every cycle regardless of state or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_hist <= '0;
      d_hist <= '0;
    end else begin
      s_hist[0] <= bus.Sout;
      d_hist[0] <= bus.Dout;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        s_hist[k] <= s_hist[k-1];
        d_hist[k] <= d_hist[k-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle strobes; flush overrides everything.
  always_comb begin
    state_nx = state;
    latch_op = 1'b0;
    clr_vld  = 1'b0;
    src_ld   = 1'b0;
    dst_ld   = 1'b0;
    incr_ld  = 1'b0;
    mdb_ack  = 1'b0;
    incr_we  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch_op = 1'b1;
          clr_vld  = 1'b1;
          state_nx = SRC;
        end
      end
      SRC: begin
        case (op.as)
          2'b00: state_nx = DST;
          2'b01: begin
            if (bus.mdb_valid) begin
              src_ld   = 1'b1;
              mdb_ack  = 1'b1;
              state_nx = DST;
            end
          end
          2'b10: begin
            src_ld   = 1'b1;
            state_nx = DST;
          end
          default: begin
            src_ld   = 1'b1;
            incr_ld  = 1'b1;
            incr_we  = 1'b1;
            state_nx = DST;
          end
        endcase
      end
      DST: begin
        if (!op.ad) begin
          state_nx = DONE;
        end else if (bus.mdb_valid) begin
          dst_ld   = 1'b1;
          mdb_ack  = 1'b1;
          state_nx = DONE;
        end
      end
      default: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
    if (bus.flush) begin
      state_nx = IDLE;
      latch_op = 1'b0;
      clr_vld  = 1'b1;
      src_ld   = 1'b0;
      dst_ld   = 1'b0;
      incr_ld  = 1'b0;
      mdb_ack  = 1'b0;
      incr_we  = 1'b0;
      done     = 1'b0;
    end
  end

  // Operation latch and address/increment result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op         <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      incr_val_q <= '0;
      src_vld_q  <= 1'b0;
      dst_vld_q  <= 1'b0;
    end else begin
      if (latch_op) op <= '{as: bus.As, ad: bus.Ad, bw: bus.BW};
      if (clr_vld) begin
        src_vld_q <= 1'b0;
        dst_vld_q <= 1'b0;
      end
      if (src_ld) begin
        src_addr_q <= src_sum;
        src_vld_q  <= 1'b1;
      end
      if (dst_ld) begin
        dst_addr_q <= d_cur + bus.MDB_out;
        dst_vld_q  <= 1'b1;
      end
      if (incr_ld) incr_val_q <= s_cur + incr_step;
    end
  end

  assign bus.mdb_ack        = mdb_ack;
  assign bus.incr_we        = incr_we;
  assign bus.done           = done;
  assign bus.busy           = (state != IDLE);
  assign bus.src_addr       = src_addr_q;
  assign bus.src_addr_valid = src_vld_q;
  assign bus.dst_addr       = dst_addr_q;
  assign bus.dst_addr_valid = dst_vld_q;
  assign bus.incr_val       = incr_val_q;

endmodule

// File: tb/tb_ea_calc_unit.sv
// Bench for ea_calc_unit: a scoreboard of expected results checked on each
// done pulse, plus per-scenario timing/handshake checks.
module tb_ea_calc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ea_calc_unit_if #(.WIDTH(16)) bus ();
  ea_calc_unit_if #(.WIDTH(16)) bus2 ();

  // Second unit with a deeper source tap sees identical stimulus.
  assign bus2.flush     = bus.flush;
  assign bus2.start     = bus.start;
  assign bus2.As        = bus.As;
  assign bus2.Ad        = bus.Ad;
  assign bus2.BW        = bus.BW;
  assign bus2.Sout      = bus.Sout;
  assign bus2.Dout      = bus.Dout;
  assign bus2.MDB_out   = bus.MDB_out;
  assign bus2.mdb_valid = bus.mdb_valid;

  ea_calc_unit #(.WIDTH(16), .HIST_DEPTH(3), .SRC_TAP(0), .DST_TAP(0)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  ea_calc_unit #(.WIDTH(16), .HIST_DEPTH(3), .SRC_TAP(2), .DST_TAP(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] src;
    logic        sv;
    logic [15:0] dst;
    logic        dv;
    logic        chk_incr;
    logic [15:0] incr;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 with no operation outstanding, wanted none");
      end else begin
        e = sb.pop_front();
        if (bus.src_addr_valid !== e.sv || (e.sv && bus.src_addr !== e.src)) begin
          errors++;
          $display("FAIL sb_src: got valid=%b addr=%h wanted valid=%b addr=%h",
                   bus.src_addr_valid, bus.src_addr, e.sv, e.src);
        end
        checks++;
        if (bus.dst_addr_valid !== e.dv || (e.dv && bus.dst_addr !== e.dst)) begin
          errors++;
          $display("FAIL sb_dst: got valid=%b addr=%h wanted valid=%b addr=%h",
                   bus.dst_addr_valid, bus.dst_addr, e.dv, e.dst);
        end
        if (e.chk_incr) begin
          checks++;
          if (bus.incr_val !== e.incr) begin
            errors++;
            $display("FAIL sb_incr: got %h wanted %h", bus.incr_val, e.incr);
          end
        end
      end
    end
  end

  // Drives one operation, pushes its expected result, and reports observed
  // handshake counts and the cycle (relative to start) at which done fired.
  task automatic drive_op(input logic [1:0] as, input logic ad, input logic bw,
                          input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] m1, input logic [15:0] m2,
                          input int sw, input int dw,
                          output int done_cyc, output int acks, output int incs);
    exp_t e;
    int ph, wc;
    bus.Sout = s;
    bus.Dout = d;
    tick();
    bus.As = as; bus.Ad = ad; bus.BW = bw; bus.start = 1'b1;
    e.src = (as == 2'b01) ? s + m1 : s;
    e.sv = (as != 2'b00);
    e.dst = d + m2;
    e.dv = ad;
    e.chk_incr = (as == 2'b11);
    e.incr = s + (bw ? 16'd1 : 16'd2);
    sb.push_back(e);
    done_cyc = -1; acks = 0; incs = 0; ph = 0; wc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = 1'b0;
      bus.mdb_valid = 1'b0;
      bus.MDB_out = 16'hDEAD;
      if (ph == 0) begin
        if (as == 2'b01) begin
          if (wc < sw) wc++;
          else begin bus.mdb_valid = 1'b1; bus.MDB_out = m1; ph = 1; wc = 0; end
        end else ph = 1;
      end else if (ph == 1) begin
        if (ad) begin
          if (wc < dw) wc++;
          else begin bus.mdb_valid = 1'b1; bus.MDB_out = m2; ph = 2; end
        end else ph = 2;
      end
      @(negedge clk);
      if (bus.mdb_ack === 1'b1) acks++;
      if (bus.incr_we === 1'b1) incs++;
      if (bus.done === 1'b1) begin done_cyc = c; break; end
    end
    tick();
    bus.mdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.mdb_ack, bus.incr_we, bus.src_addr_valid,
         bus.dst_addr_valid, bus.src_addr, bus.dst_addr, bus.incr_val} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b src=%h dst=%h incr=%h wanted all zero",
               bus.busy, bus.done, bus.src_addr, bus.dst_addr, bus.incr_val);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_indirect();
    int dc, ak, ic;
    drive_op(2'b10, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0, 16'h0, 0, 0, dc, ak, ic);
    checks++;
    if (dc != 3 || ak != 0 || ic != 0) begin
      errors++;
      $display("FAIL indirect_timing: got done_cyc=%0d acks=%0d incr=%0d wanted 3/0/0", dc, ak, ic);
    end
  endtask

  task automatic test_indexed();
    int dc, ak, ic;
    drive_op(2'b01, 1'b1, 1'b0, 16'h0100, 16'h0300, 16'h0010, 16'h0020, 2, 0, dc, ak, ic);
    checks++;
    if (dc != 5 || ak != 2) begin
      errors++;
      $display("FAIL indexed_timing: got done_cyc=%0d acks=%0d wanted 5/2", dc, ak);
    end
  endtask

  task automatic test_autoinc();
    int dc, ak, ic;
    drive_op(2'b11, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 0, 0, dc, ak, ic);
    checks++;
    if (dc != 3 || ic != 1 || ak != 0) begin
      errors++;
      $display("FAIL autoinc_word: got done_cyc=%0d incr_pulses=%0d acks=%0d wanted 3/1/0", dc, ic, ak);
    end
    drive_op(2'b11, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 0, 0, dc, ak, ic);
    checks++;
    if (dc != 3 || ic != 1) begin
      errors++;
      $display("FAIL autoinc_byte: got done_cyc=%0d incr_pulses=%0d wanted 3/1", dc, ic);
    end
  endtask

  task automatic test_tap();
    exp_t e;
    tick(); bus.Sout = 16'h0010;
    tick(); bus.Sout = 16'h0020;
    tick(); bus.Sout = 16'h0030;
    bus.As = 2'b10; bus.Ad = 1'b0; bus.BW = 1'b0; bus.start = 1'b1;
    e.src = 16'h0030; e.sv = 1'b1; e.dst = 16'h0; e.dv = 1'b0;
    e.chk_incr = 1'b0; e.incr = 16'h0;
    sb.push_back(e);
    tick(); bus.start = 1'b0; bus.Sout = 16'h0040;
    tick(); bus.Sout = 16'h0050;
    @(negedge clk);
    checks++;
    if (bus.src_addr !== 16'h0030 || bus.src_addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL tap0_src: got %h valid=%b wanted 0030 valid=1", bus.src_addr, bus.src_addr_valid);
    end
    checks++;
    if (bus2.src_addr !== 16'h0010 || bus2.src_addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL tap2_src: got %h valid=%b wanted 0010 valid=1", bus2.src_addr, bus2.src_addr_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL tap_done: got done=%b at cycle 3 wanted 1", bus.done);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.Sout = 16'h1234;
    tick();
    bus.As = 2'b10; bus.Ad = 1'b1; bus.BW = 1'b0; bus.start = 1'b1;
    tick();
    bus.As = 2'b00;  // start kept high while busy: must be ignored
    tick();
    bus.start = 1'b0; bus.As = 2'b10; bus.mdb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.src_addr_valid !== 1'b1 || bus.src_addr !== 16'h1234) begin
      errors++;
      $display("FAIL busy_start_ignored: got busy=%b src_valid=%b src=%h wanted 1/1/1234",
               bus.busy, bus.src_addr_valid, bus.src_addr);
    end
    tick();
    bus.flush = 1'b1; bus.mdb_valid = 1'b1; bus.MDB_out = 16'h0055;
    @(negedge clk);
    checks++;
    if (bus.mdb_ack !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack: got mdb_ack=%b done=%b wanted 0/0", bus.mdb_ack, bus.done);
    end
    tick();
    bus.flush = 1'b0; bus.mdb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.src_addr_valid !== 1'b0 || bus.dst_addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b src_valid=%b dst_valid=%b wanted 0/0/0",
               bus.busy, bus.src_addr_valid, bus.dst_addr_valid);
    end
    repeat (3) tick();
  endtask

  task automatic test_rst_mid();
    int dc, ak, ic;
    bus.Sout = 16'h0777;
    tick();
    bus.As = 2'b01; bus.Ad = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.mdb_valid = 1'b0;
    tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mdb_ack, bus.incr_we, bus.src_addr_valid,
         bus.dst_addr_valid, bus.src_addr, bus.dst_addr, bus.incr_val} !== '0) begin
      errors++;
      $display("FAIL async_rst: got busy=%b src=%h dst=%h src_valid=%b wanted all zero",
               bus.busy, bus.src_addr, bus.dst_addr, bus.src_addr_valid);
    end
    tick();
    rst = 1'b0;
    drive_op(2'b10, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0, 16'h0, 0, 0, dc, ak, ic);
    checks++;
    if (dc != 3) begin
      errors++;
      $display("FAIL post_rst_op: got done_cyc=%0d wanted 3", dc);
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.start = 1'b0; bus.As = 2'b00; bus.Ad = 1'b0; bus.BW = 1'b0;
    bus.Sout = '0; bus.Dout = '0; bus.MDB_out = '0; bus.mdb_valid = 1'b0;
    test_reset();
    test_indirect();
    test_indexed();
    test_autoinc();
    test_tap();
    test_flush();
    test_rst_mid();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding operations wanted 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
